regfile_scoreboard: RTL and testbench

- Parametrised successor to the 32-entry register file: configurable depth and width, optional hardwired-zero register 0, write-to-read bypass and a per-register busy scoreboard.
- Sits between decode and write-back in the pipelined core.
- Decode reads two operands and learns whether each is still owed by an in-flight producer.
- Write-back stores results and retires the pending flag.

---
 rtl/regfile_scoreboard.sv | 84 ++++++++
 tb/tb_regfile_scoreboard.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with two combinational read ports, one write-back port,
// optional hardwired-zero register 0, write-to-read bypass and a per-register busy scoreboard.
module regfile_scoreboard #(
  parameter int width    = 32,
  parameter int depth    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int AW       = $clog2(depth)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [AW-1:0]            A_addr,
  input  logic [AW-1:0]            B_addr,
  output logic [width-1:0]         A_data,
  output logic [width-1:0]         B_data,
  output logic                     A_busy,
  output logic                     B_busy,
  input  logic [AW-1:0]            W_addr,
  input  logic [width-1:0]         W_data,
  input  logic                     wr_enable,
  input  logic                     issue_valid,
  input  logic [AW-1:0]            issue_addr,
  output logic [AW:0]              busy_count,
  output logic [depth*width-1:0]   debug_reg_out
);

  logic [width-1:0] r_regs [depth];
  logic [depth-1:0] r_busy;
  logic [AW:0]      r_busy_count;

  logic [depth-1:0] w_busy_next;
  logic [AW:0]      w_pop;
  logic             w_wr_ok;
  logic             w_iss_ok;
  logic             w_zero_a;
  logic             w_zero_b;
  logic             w_hit_a;
  logic             w_hit_b;

  // Register 0 swallows writes and issues when it is hardwired to zero.
  assign w_wr_ok  = wr_enable   && !((ZERO_REG != 0) && (W_addr == '0));
  assign w_iss_ok = issue_valid && !((ZERO_REG != 0) && (issue_addr == '0));
  assign w_zero_a = (ZERO_REG != 0) && (A_addr == '0);
  assign w_zero_b = (ZERO_REG != 0) && (B_addr == '0);

  // A bypass hit means the value being written this cycle is the freshest one.
  assign w_hit_a = (BYPASS != 0) && !reset && w_wr_ok && (W_addr == A_addr);
  assign w_hit_b = (BYPASS != 0) && !reset && w_wr_ok && (W_addr == B_addr);

  always_comb begin
    w_busy_next = r_busy;
    if (wr_enable) w_busy_next[W_addr] = 1'b0;
    // Issue is applied after write-back so a new producer wins over a retiring one.
    if (w_iss_ok) w_busy_next[issue_addr] = 1'b1;
    if (reset) w_busy_next = '0;
    w_pop = '0;
    for (int i = 0; i < depth; i++) begin
      w_pop = w_pop + {{AW{1'b0}}, w_busy_next[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy       <= '0;
      r_busy_count <= '0;
      for (int i = 0; i < depth; i++) r_regs[i] <= '0;
    end else begin
      r_busy       <= w_busy_next;
      r_busy_count <= w_pop;
      if (w_wr_ok) r_regs[W_addr] <= W_data;
    end
  end

  assign A_data = w_zero_a ? '0 : (w_hit_a ? W_data : r_regs[A_addr]);
  assign B_data = w_zero_b ? '0 : (w_hit_b ? W_data : r_regs[B_addr]);
  assign A_busy = r_busy[A_addr] & ~w_hit_a;
  assign B_busy = r_busy[B_addr] & ~w_hit_b;
  assign busy_count = r_busy_count;

  for (genvar g = 0; g < depth; g++) begin : g_dbg
    assign debug_reg_out[g*width +: width] = r_regs[g];
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: two instances (zero-reg+bypass, and neither)
// driven in lockstep and checked against an array-based reference model.
module tb_regfile_scoreboard;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AW = 5;
  localparam int NC = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic [AW-1:0] a_addr = '0;
  logic [AW-1:0] b_addr = '0;
  logic [AW-1:0] w_addr = '0;
  logic [W-1:0]  w_data = '0;
  logic          wr_enable = 1'b0;
  logic          issue_valid = 1'b0;
  logic [AW-1:0] issue_addr = '0;

  logic [W-1:0]   a_data [NC];
  logic [W-1:0]   b_data [NC];
  logic           a_busy [NC];
  logic           b_busy [NC];
  logic [AW:0]    busy_cnt [NC];
  logic [D*W-1:0] dbg [NC];

  regfile_scoreboard #(.width(W), .depth(D), .ZERO_REG(1), .BYPASS(1)) u_dut0 (
    .clk(clk), .reset(reset),
    .A_addr(a_addr), .B_addr(b_addr),
    .A_data(a_data[0]), .B_data(b_data[0]),
    .A_busy(a_busy[0]), .B_busy(b_busy[0]),
    .W_addr(w_addr), .W_data(w_data), .wr_enable(wr_enable),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .busy_count(busy_cnt[0]), .debug_reg_out(dbg[0])
  );

  regfile_scoreboard #(.width(W), .depth(D), .ZERO_REG(0), .BYPASS(0)) u_dut1 (
    .clk(clk), .reset(reset),
    .A_addr(a_addr), .B_addr(b_addr),
    .A_data(a_data[1]), .B_data(b_data[1]),
    .A_busy(a_busy[1]), .B_busy(b_busy[1]),
    .W_addr(w_addr), .W_data(w_data), .wr_enable(wr_enable),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .busy_count(busy_cnt[1]), .debug_reg_out(dbg[1])
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [W-1:0]   a_data;
    logic [W-1:0]   b_data;
    logic           a_busy;
    logic           b_busy;
    logic [AW:0]    cnt;
    logic [D*W-1:0] dbg;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic [EXP_W-1:0] exp0_q[$];
  logic [EXP_W-1:0] exp1_q[$];

  logic [W-1:0] m_reg  [NC][D];
  bit           m_busy [NC][D];

  int n_cmp = 0;
  int n_err = 0;

  function automatic bit cfg_zr(int c); return (c == 0); endfunction
  function automatic bit cfg_bp(int c); return (c == 0); endfunction

  function automatic bit hit(int c, logic [AW-1:0] a);
    return cfg_bp(c) && wr_enable && !reset && (w_addr == a) && !(cfg_zr(c) && a == 0);
  endfunction

  function automatic logic [W-1:0] rd(int c, logic [AW-1:0] a);
    if (cfg_zr(c) && a == 0) return '0;
    if (hit(c, a)) return w_data;
    return m_reg[c][a];
  endfunction

  function automatic exp_t model_out(int c);
    exp_t e;
    int   n = 0;
    e.a_data = rd(c, a_addr);
    e.b_data = rd(c, b_addr);
    e.a_busy = m_busy[c][a_addr] && !hit(c, a_addr);
    e.b_busy = m_busy[c][b_addr] && !hit(c, b_addr);
    for (int i = 0; i < D; i++) begin
      n += int'(m_busy[c][i]);
      e.dbg[i*W +: W] = m_reg[c][i];
    end
    e.cnt = (AW+1)'(n);
    return e;
  endfunction

  task automatic model_step(int c);
    if (reset) begin
      for (int i = 0; i < D; i++) begin
        m_reg[c][i]  = '0;
        m_busy[c][i] = 1'b0;
      end
    end else begin
      if (wr_enable && !(cfg_zr(c) && w_addr == 0)) m_reg[c][w_addr] = w_data;
      if (wr_enable) m_busy[c][w_addr] = 1'b0;
      if (issue_valid && !(cfg_zr(c) && issue_addr == 0)) m_busy[c][issue_addr] = 1'b1;
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit chk, input bit rst, input bit we,
                       input logic [AW-1:0] wa, input logic [W-1:0] wd,
                       input logic [AW-1:0] aa, input logic [AW-1:0] ba,
                       input bit iv, input logic [AW-1:0] ia);
    @(posedge clk);
    #2;
    reset = rst; wr_enable = we; w_addr = wa; w_data = wd;
    a_addr = aa; b_addr = ba; issue_valid = iv; issue_addr = ia;
    if (chk) begin
      exp0_q.push_back(model_out(0));
      exp1_q.push_back(model_out(1));
    end
    model_step(0);
    model_step(1);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 3));
    return AW'($urandom_range(0, D-1));
  endfunction

  // ---------------- scoreboard monitor ----------------
  task automatic check(int c, exp_t e);
    n_cmp++;
    if (a_data[c] !== e.a_data) begin
      n_err++; $display("FAIL c%0d a_data got %h exp %h (A_addr=%0d)", c, a_data[c], e.a_data, a_addr);
    end
    n_cmp++;
    if (b_data[c] !== e.b_data) begin
      n_err++; $display("FAIL c%0d b_data got %h exp %h (B_addr=%0d)", c, b_data[c], e.b_data, b_addr);
    end
    n_cmp++;
    if (a_busy[c] !== e.a_busy) begin
      n_err++; $display("FAIL c%0d a_busy got %b exp %b (A_addr=%0d)", c, a_busy[c], e.a_busy, a_addr);
    end
    n_cmp++;
    if (b_busy[c] !== e.b_busy) begin
      n_err++; $display("FAIL c%0d b_busy got %b exp %b (B_addr=%0d)", c, b_busy[c], e.b_busy, b_addr);
    end
    n_cmp++;
    if (busy_cnt[c] !== e.cnt) begin
      n_err++; $display("FAIL c%0d busy_count got %0d exp %0d", c, busy_cnt[c], e.cnt);
    end
    n_cmp++;
    if (dbg[c] !== e.dbg) begin
      n_err++;
      for (int i = 0; i < D; i++) begin
        if (dbg[c][i*W +: W] !== e.dbg[i*W +: W]) begin
          $display("FAIL c%0d debug_reg_out reg %0d got %h exp %h", c, i, dbg[c][i*W +: W], e.dbg[i*W +: W]);
          break;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp0_q.size() > 0) check(0, exp_t'(exp0_q.pop_front()));
      if (exp1_q.size() > 0) check(1, exp_t'(exp1_q.pop_front()));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int c = 0; c < NC; c++)
      for (int i = 0; i < D; i++) begin
        m_reg[c][i]  = '0;
        m_busy[c][i] = 1'b0;
      end

    // Bring both instances out of an unknown state.
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    // Reset with a live write/issue: bypass suppressed, nothing recorded.
    drive(1, 1, 1, 5, 32'hCAFE_F00D, 5, 5, 1, 5);

    // Read every address on both ports after reset.
    for (int i = 0; i < D; i++) drive(1, 0, 0, 0, 0, AW'(i), AW'(D-1-i), 0, 0);

    // Same-cycle bypass of a write, then the stored value.
    drive(1, 0, 1, 5, 32'hDEAD_BEEF, 5, 5, 0, 0);
    drive(1, 0, 0, 0, 0, 5, 0, 0, 0);

    // Writes and issues to register 0.
    drive(1, 0, 1, 0, 32'h1234_5678, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Issue r7, wait, write back r7 while reading it.
    drive(1, 0, 0, 0, 0, 7, 7, 1, 7);
    drive(1, 0, 0, 0, 0, 7, 7, 0, 0);
    drive(1, 0, 0, 0, 0, 7, 7, 0, 0);
    drive(1, 0, 1, 7, 32'hA5, 7, 7, 0, 0);
    drive(1, 0, 0, 0, 0, 7, 7, 0, 0);

    // Issue and write-back to r9 in the same cycle: issue wins.
    drive(1, 0, 1, 9, 32'h1, 9, 9, 1, 9);
    drive(1, 0, 0, 0, 0, 9, 9, 0, 0);

    // Issue r1..r31 back to back with a reset in the middle.
    for (int i = 1; i < D; i++) drive(1, (i == 20), 0, 0, 0, AW'(i), AW'(i-1), 1, AW'(i));
    drive(1, 0, 0, 0, 0, 20, 25, 0, 0);

    // Fill every register busy to reach the top of the count range.
    for (int i = 0; i < D; i++) drive(1, 0, 0, 0, 0, AW'(i), 0, 1, AW'(i));
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0);

    // Randomized traffic with frequent address collisions.
    for (int n = 0; n < 600; n++) begin
      drive(1, ($urandom_range(0, 63) == 0), ($urandom_range(0, 2) != 0), rand_addr(), $urandom(),
            rand_addr(), rand_addr(), ($urandom_range(0, 2) != 0), rand_addr());
    end
    drive(1, 0, 0, 0, 0, 3, 4, 0, 0);

    // Let the monitor drain, bounded.
    begin
      int budget = 20;
      while ((exp0_q.size() > 0 || exp1_q.size() > 0) && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (exp0_q.size() > 0 || exp1_q.size() > 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL drain pending %0d/%0d exp 0/0", exp0_q.size(), exp1_q.size());
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
